// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver clocked by clk, bit-timed by an edge-detected 16x baud toggle.
// Mid-bit 3-sample majority vote; 1-entry valid/ready holding register with error pulses.
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SAMPLE_MID = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud16_in,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] VOTE_A   = CNT_W'(SAMPLE_MID - 1);
    localparam logic [CNT_W-1:0] VOTE_B   = CNT_W'(SAMPLE_MID);
    localparam logic [CNT_W-1:0] VOTE_C   = CNT_W'(SAMPLE_MID + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 rx_meta_q, rx_sync_q, rx_s_q, baud16_q;
    logic                 rx_s, tick_s, decide_s, wrap_s, vote_s, load_s, ferr_s;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_q;

    assign rx_s     = rx_sync_q;
    assign tick_s   = baud16_in & ~baud16_q;
    assign decide_s = tick_s && (cnt_q == VOTE_C);
    assign wrap_s   = tick_s && (cnt_q == CNT_LAST);
    assign vote_s   = maj3(smp_q[0], smp_q[1], rx_s);

    // Input conditioning: rx synchroniser, its delayed copy, baud16 edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_s_q    <= 1'b1;
            baud16_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_s_q    <= rx_sync_q;
            baud16_q  <= baud16_in;
        end
    end

    // Receive FSM next-state, tick counter, vote capture and shift logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        smp_d   = smp_q;
        load_s  = 1'b0;
        ferr_s  = 1'b0;
        if (tick_s) begin
            cnt_d = (cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == VOTE_A) begin
                smp_d[0] = rx_s;
            end else if (cnt_q == VOTE_B) begin
                smp_d[1] = rx_s;
            end else begin
                smp_d = smp_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            S_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                idx_d = {IDX_W{1'b0}};
                if (rx_s_q && !rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (decide_s && vote_s) begin
                    state_d = S_IDLE;
                end else if (wrap_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (decide_s) begin
                    shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                end else if (wrap_s) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (decide_s) begin
                    // A low stop bit means a framing error or break; wait out the low line.
                    if (vote_s) begin
                        load_s  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            shift_q <= {DATA_BITS{1'b0}};
            smp_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            smp_q   <= smp_d;
        end
    end

    // Holding register, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q   <= {DATA_BITS{1'b0}};
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_data_q   <= load_s ? shift_q : rx_data_q;
            rx_valid_q  <= load_s | (rx_valid_q & ~rx_ready);
            frame_err_q <= ferr_s;
            overrun_q   <= load_s & rx_valid_q & ~rx_ready;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x; baud16 toggles every 2 clk so 1 bit = 16 ticks = 64 clk.
module tb_uart_rx_16x;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud16_in = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    int checks = 0;
    int failures = 0;
    int valid_cyc = 0;
    int ferr_cyc = 0;
    int ovr_cyc = 0;
    logic [7:0] last_data = 8'h00;
    int v0, f0, o0;

    uart_rx_16x dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud16_in (baud16_in),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (2) @(negedge clk);
            baud16_in = ~baud16_in;
        end
    end

    // Output monitor: counts cycles each output is high and captures delivered bytes.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cyc <= valid_cyc + 1;
            last_data <= rx_data;
        end
        if (frame_err) ferr_cyc <= ferr_cyc + 1;
        if (overrun)   ovr_cyc  <= ovr_cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        v0 = valid_cyc;
        f0 = ferr_cyc;
        o0 = ovr_cyc;
    endtask

    // Drives start, 8 data bits LSB first and a stop bit, aligned to a baud16 rise.
    // flip_pos inverts rx for 4 clk around the count-8 sample of that bit position.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int flip_pos, input int abort_at);
        logic [9:0] bits;
        logic       v;
        bits = {stop, b, 1'b0};
        @(posedge baud16_in);
        for (int t = 0; t < 640; t++) begin
            if (abort_at >= 0 && t >= abort_at) break;
            v = bits[t / 64];
            if ((t / 64) == flip_pos && (t % 64) >= 32 && (t % 64) < 36) v = ~v;
            rx = v;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("reset_data", {24'd0, rx_data}, 32'h0);
        check_eq("reset_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("reset_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        // 1: clean frame, consumer ready
        snap();
        send_frame(8'h55, 1'b1, -1, -1);
        idle(20);
        check_eq("t1_valid_cycles", valid_cyc - v0, 32'd1);
        check_eq("t1_data", {24'd0, last_data}, 32'h55);
        check_eq("t1_ferr", ferr_cyc - f0, 32'd0);
        check_eq("t1_ovr", ovr_cyc - o0, 32'd0);

        // 2: 3-tick glitch is a false start
        snap();
        @(posedge baud16_in);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        idle(200);
        check_eq("t2_valid", valid_cyc - v0, 32'd0);
        check_eq("t2_ferr", ferr_cyc - f0, 32'd0);

        // 3: framing error with break, then recovery
        snap();
        send_frame(8'hA3, 1'b0, -1, -1);
        repeat (128) @(negedge clk);
        rx = 1'b1;
        idle(64);
        check_eq("t3_ferr_pulse", ferr_cyc - f0, 32'd1);
        check_eq("t3_no_valid", valid_cyc - v0, 32'd0);
        snap();
        send_frame(8'h0F, 1'b1, -1, -1);
        idle(20);
        check_eq("t3_valid_cycles", valid_cyc - v0, 32'd1);
        check_eq("t3_data", {24'd0, last_data}, 32'h0F);

        // 5: single flipped sample in data bit 3 is outvoted
        snap();
        send_frame(8'h81, 1'b1, 4, -1);
        idle(20);
        check_eq("t5_valid_cycles", valid_cyc - v0, 32'd1);
        check_eq("t5_data", {24'd0, last_data}, 32'h81);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, -1, -1);
        idle(20);
        check_eq("t4_first_data", {24'd0, rx_data}, 32'h11);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(20);
        check_eq("t4_ovr_pulse", ovr_cyc - o0, 32'd1);
        check_eq("t4_data", {24'd0, rx_data}, 32'h22);
        check_eq("t4_valid_held", {31'd0, rx_valid}, 32'd1);

        // 6: reset mid data bit 3 with a byte still held
        send_frame(8'hA5, 1'b1, -1, 288);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t6_rst_data", {24'd0, rx_data}, 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        idle(20);
        snap();
        send_frame(8'hC3, 1'b1, -1, -1);
        idle(20);
        check_eq("t6_valid_cycles", valid_cyc - v0, 32'd1);
        check_eq("t6_data", {24'd0, last_data}, 32'hC3);
        check_eq("t6_ferr", ferr_cyc - f0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
